// File: rtl/simon_core.sv
// simon_core: Simon game controller and datapath.
// Records a growing sequence of WIDTH-bit button patterns, plays it back on
// the LEDs from an internal timer, checks the player's repetition of it and
// keeps a score of the longest sequence repeated correctly.
module simon_core #(
  parameter int WIDTH      = 4,
  parameter int ADDR_W     = 6,
  parameter int PLAY_TICKS = 4
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              press,
  input  logic              level,
  input  logic [WIDTH-1:0]  pattern,
  output logic [WIDTH-1:0]  pattern_leds,
  output logic [2:0]        mode_leds,
  output logic [ADDR_W:0]   score,
  output logic              win
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int TICK_W = $clog2(PLAY_TICKS) + 1;

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C     = (ADDR_W + 1)'(1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PLAY_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_INPUT    = 2'd0,
    S_PLAYBACK = 2'd1,
    S_REPEAT   = 2'd2,
    S_DONE     = 2'd3
  } mode_e;

  // Easy level takes a single button; hard level takes any non-empty chord.
  function automatic logic is_legal(input logic [WIDTH-1:0] pat, input logic hard);
    logic nonzero;
    logic one_hot;
    nonzero = (pat != '0);
    one_hot = nonzero && ((pat & (pat - WIDTH'(1))) == '0);
    return hard ? nonzero : one_hot;
  endfunction

  function automatic logic [2:0] mode_code(input mode_e m);
    logic [2:0] code;
    case (m)
      S_INPUT:    code = 3'b001;
      S_PLAYBACK: code = 3'b010;
      S_REPEAT:   code = 3'b100;
      default:    code = 3'b111;
    endcase
    return code;
  endfunction

  mode_e             mode_q, mode_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [ADDR_W:0]   score_q, score_d;
  logic              win_q, win_d;
  logic              level_r_q;
  logic [WIDTH-1:0]  leds_q, leds_d;
  logic [2:0]        mode_leds_q, mode_leds_d;

  // Sequence storage is deliberately left uninitialised; count bounds every use.
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              mem_we;
  logic [WIDTH-1:0]  mem_rd;
  logic              at_last;

  assign mem_rd  = mem_q[idx_q];
  assign at_last = ({1'b0, idx_q} == (count_q - ONE_C));

  // Next-state, memory write enable and registered-output values.
  always_comb begin
    mode_d  = mode_q;
    count_d = count_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    score_d = score_q;
    win_d   = win_q;
    leds_d  = leds_q;
    mem_we  = 1'b0;

    case (mode_q)
      S_INPUT: begin
        leds_d = pattern;
        if (press && is_legal(pattern, level_r_q)) begin
          mem_we  = 1'b1;
          count_d = count_q + ONE_C;
          idx_d   = '0;
          tick_d  = '0;
          mode_d  = S_PLAYBACK;
        end
      end
      S_PLAYBACK: begin
        leds_d = mem_rd;
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (at_last) begin
            idx_d  = '0;
            mode_d = S_REPEAT;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      S_REPEAT: begin
        leds_d = pattern;
        if (press) begin
          if (pattern == mem_rd) begin
            if (at_last) begin
              score_d = count_q;
              if (count_q == DEPTH_C) begin
                mode_d = S_DONE;
                win_d  = 1'b1;
              end else begin
                mode_d = S_INPUT;
              end
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            mode_d = S_DONE;
            win_d  = 1'b0;
            idx_d  = '0;
          end
        end
      end
      default: begin
        leds_d = mem_rd;
        if (press) begin
          idx_d = at_last ? '0 : idx_q + IDX_ONE;
        end
      end
    endcase

    mode_leds_d = mode_code(mode_d);
  end

  // Control and output registers; reset wins over any press on the same edge.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      mode_q      <= S_INPUT;
      count_q     <= '0;
      idx_q       <= '0;
      tick_q      <= '0;
      score_q     <= '0;
      win_q       <= 1'b0;
      level_r_q   <= level;
      leds_q      <= '0;
      mode_leds_q <= 3'b001;
    end else begin
      mode_q      <= mode_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      tick_q      <= tick_d;
      score_q     <= score_d;
      win_q       <= win_d;
      leds_q      <= leds_d;
      mode_leds_q <= mode_leds_d;
    end
  end

  // Sequence memory write port, addressed by the number of entries already held.
  always_ff @(posedge sysclk) begin
    if (mem_we && !rst) begin
      mem_q[count_q[ADDR_W-1:0]] <= pattern;
    end
  end

  assign pattern_leds = leds_q;
  assign mode_leds    = mode_leds_q;
  assign score        = score_q;
  assign win          = win_q;

endmodule

// File: tb/tb_simon_core.sv
// Testbench for simon_core: directed game scenarios followed by random play,
// every cycle compared against a sequence-level reference model.
module tb_simon_core;

  localparam int WIDTH      = 4;
  localparam int ADDR_W     = 2;
  localparam int PLAY_TICKS = 4;
  localparam int DEPTH      = 4;

  logic              sysclk = 1'b0;
  logic              rst;
  logic              press;
  logic              level;
  logic [WIDTH-1:0]  pattern;
  logic [WIDTH-1:0]  pattern_leds;
  logic [2:0]        mode_leds;
  logic [ADDR_W:0]   score;
  logic              win;

  always #5 sysclk = ~sysclk;

  simon_core #(
    .WIDTH      (WIDTH),
    .ADDR_W     (ADDR_W),
    .PLAY_TICKS (PLAY_TICKS)
  ) dut (
    .sysclk       (sysclk),
    .rst          (rst),
    .press        (press),
    .level        (level),
    .pattern      (pattern),
    .pattern_leds (pattern_leds),
    .mode_leds    (mode_leds),
    .score        (score),
    .win          (win)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the game as a list of stored patterns plus a play position.
  // Modes: 0 = entering, 1 = showing, 2 = repeating, 3 = finished.
  int               m_mode = 0;
  logic [WIDTH-1:0] m_seq[$];
  int               m_pos = 0;
  int               m_elapsed = 0;
  int               m_score = 0;
  bit               m_win = 0;
  bit               m_level = 0;
  logic [WIDTH-1:0] m_leds = '0;
  bit               lvl_drv = 0;

  function automatic logic [2:0] mode_code(input int m);
    case (m)
      0: return 3'b001;
      1: return 3'b010;
      2: return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  function automatic bit legal(input logic [WIDTH-1:0] p, input bit hard);
    if (hard) return p != 0;
    return $countones(p) == 1;
  endfunction

  task automatic model_edge(input bit r, input bit p, input logic [WIDTH-1:0] pat, input bit lvl);
    int n;
    if (r) begin
      m_mode = 0; m_seq.delete(); m_pos = 0; m_elapsed = 0;
      m_score = 0; m_win = 0; m_level = lvl; m_leds = '0;
    end else begin
      n = int'(m_seq.size());
      case (m_mode)
        0: begin
          m_leds = pat;
          if (p && legal(pat, m_level)) begin
            m_seq.push_back(pat);
            m_elapsed = 0;
            m_mode = 1;
          end
        end
        1: begin
          // Entry k is on display for elapsed cycles k*PLAY_TICKS .. (k+1)*PLAY_TICKS-1.
          m_leds = m_seq[m_elapsed / PLAY_TICKS];
          m_elapsed++;
          if (m_elapsed == n * PLAY_TICKS) begin
            m_mode = 2;
            m_pos = 0;
          end
        end
        2: begin
          m_leds = pat;
          if (p) begin
            if (pat == m_seq[m_pos]) begin
              if (m_pos == n - 1) begin
                m_score = n;
                if (n == DEPTH) begin
                  m_mode = 3;
                  m_win = 1;
                end else begin
                  m_mode = 0;
                end
              end else begin
                m_pos++;
              end
            end else begin
              m_mode = 3;
              m_win = 0;
              m_pos = 0;
            end
          end
        end
        default: begin
          m_leds = m_seq[m_pos];
          if (p) m_pos = (m_pos + 1) % n;
        end
      endcase
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit p, input logic [WIDTH-1:0] pat);
    rst = r;
    press = p;
    pattern = pat;
    level = lvl_drv;
    model_edge(r, p, pat, lvl_drv);
    @(posedge sysclk);
    #1;
    check("pattern_leds", 32'(pattern_leds), 32'(m_leds));
    check("mode_leds", 32'(mode_leds), 32'(mode_code(m_mode)));
    check("score", 32'(score), 32'(m_score));
    check("win", 32'(win), 32'(m_win));
  endtask

  task automatic wait_playback();
    for (int i = 0; i < 64 && m_mode == 1; i++) step(0, 0, 4'($urandom));
  endtask

  task automatic play_round(input logic [WIDTH-1:0] p);
    int n;
    step(0, 1, p);
    wait_playback();
    n = int'(m_seq.size());
    for (int i = 0; i < n; i++) step(0, 1, m_seq[i]);
  endtask

  bit               r_b;
  bit               p_b;
  logic [WIDTH-1:0] pat_v;

  initial begin
    rst = 1'b1; press = 1'b0; level = 1'b0; pattern = '0;
    #2;

    // Basic round at easy level.
    lvl_drv = 0;
    step(1, 0, 4'b0000);
    check("reset_mode", 32'(mode_leds), 32'h1);
    check("reset_leds", 32'(pattern_leds), 32'h0);
    step(0, 1, 4'b0011);
    check("illegal_ignored", 32'(mode_leds), 32'h1);
    step(0, 1, 4'b0100);
    check("enter_playback", 32'(mode_leds), 32'h2);
    wait_playback();
    check("after_playback", 32'(mode_leds), 32'h4);
    step(0, 1, 4'b0100);
    check("score_1", 32'(score), 32'h1);
    play_round(4'b0001);
    check("score_2", 32'(score), 32'h2);
    check("mode_after_2", 32'(mode_leds), 32'h1);

    // Mismatch on the second entry, then wrap through the stored sequence.
    step(1, 0, 4'b0000);
    play_round(4'b0100);
    step(0, 1, 4'b0001);
    wait_playback();
    step(0, 1, 4'b0100);
    step(0, 1, 4'b1000);
    check("mismatch_mode", 32'(mode_leds), 32'h7);
    check("mismatch_win", 32'(win), 32'h0);
    step(0, 0, 4'b0000);
    check("done_first_led", 32'(pattern_leds), 32'h4);
    for (int i = 0; i < 4; i++) step(0, 1, 4'($urandom));

    // Level is captured only during reset.
    lvl_drv = 1;
    step(1, 0, 4'b0000);
    lvl_drv = 0;
    step(0, 1, 4'b1011);
    check("hard_accept", 32'(mode_leds), 32'h2);
    wait_playback();
    step(0, 1, 4'b1011);
    step(0, 1, 4'b0000);
    check("zero_ignored", 32'(mode_leds), 32'h1);
    step(0, 1, 4'b0110);
    check("hard_chord", 32'(mode_leds), 32'h2);
    wait_playback();

    // Fill the whole memory for a win.
    step(1, 0, 4'b0000);
    play_round(4'b0001);
    play_round(4'b0010);
    play_round(4'b0100);
    play_round(4'b1000);
    check("full_mode", 32'(mode_leds), 32'h7);
    check("full_win", 32'(win), 32'h1);
    check("full_score", 32'(score), 32'h4);
    for (int i = 0; i < 6; i++) step(0, 1, 4'($urandom));
    step(0, 0, 4'b0000);

    // Reset in the middle of playback discards the sequence.
    step(1, 0, 4'b0000);
    step(0, 1, 4'b0010);
    step(0, 0, 4'b0000);
    step(1, 1, 4'b0001);
    check("midreset_mode", 32'(mode_leds), 32'h1);
    check("midreset_leds", 32'(pattern_leds), 32'h0);
    check("midreset_score", 32'(score), 32'h0);
    step(0, 1, 4'b1000);
    wait_playback();
    check("single_entry", 32'(mode_leds), 32'h4);
    step(0, 1, 4'b1000);
    check("single_score", 32'(score), 32'h1);

    // Random play against the model.
    for (int c = 0; c < 4000; c++) begin
      r_b = ($urandom_range(0, 99) == 0);
      p_b = ($urandom_range(0, 99) < 40);
      pat_v = 4'($urandom);
      if (m_mode == 2 && $urandom_range(0, 99) < 85) pat_v = m_seq[m_pos];
      else if (m_mode == 0 && $urandom_range(0, 99) < 70) pat_v = 4'(1 << $urandom_range(0, 3));
      if (r_b) lvl_drv = bit'($urandom_range(0, 1));
      step(r_b, p_b, pat_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
